// File: rtl/dnn_pkg.sv
// Shared types for the DNN control path: table geometry, sequencer states and per-layer config.
package dnn_pkg;
    localparam int IDX_W    = 4;
    localparam int N_LAYERS = 16;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} seq_state_t;

    typedef struct packed {
        logic [IDX_W-1:0] num_p;
        logic             need_act;
    } layer_cfg_t;
endpackage

// File: rtl/layer_cfg_table.sv
// Per-layer configuration registers: synchronous write, asynchronous read, active-low sync clear.
module layer_cfg_table
    import dnn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  layer_cfg_t       wdata,
    input  logic [IDX_W-1:0] raddr,
    output layer_cfg_t       rdata
);
    layer_cfg_t entries [N_LAYERS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_LAYERS; i++) begin
                entries[i] <= '0;
            end
        end else if (we) begin
            entries[waddr] <= wdata;
        end
    end

    assign rdata = entries[raddr];
endmodule

// File: rtl/layer_sequencer.sv
// Walks the programmed layers/partitions and hands one job at a time to the distributor.
// Optional WAIT watchdog is compiled in with LAYER_SEQ_TIMEOUT_EN.
module layer_sequencer
    import dnn_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             m_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] num_layers,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_layer,
    input  logic [IDX_W-1:0] cfg_num_p,
    input  logic             cfg_need_act,
    input  logic             all_done,
    output logic             dis_en,
    output logic [IDX_W-1:0] layer_index,
    output logic [IDX_W-1:0] p_index,
    output logic             need_act,
    output logic             busy,
    output logic             done,
    output logic             timeout
);
    seq_state_t       state;
    seq_state_t       state_next;
    logic [IDX_W-1:0] last_layer;
    layer_cfg_t       cur_cfg;
    layer_cfg_t       cfg_wdata;
    logic             table_we;
    logic             last_job;
    logic             wait_expired;

    // The table is frozen for the whole run; writes only land while idle.
    assign table_we  = cfg_we && (state == IDLE);
    assign cfg_wdata = '{num_p: cfg_num_p, need_act: cfg_need_act};

    layer_cfg_table u_table (
        .clk   (m_clk),
        .rst   (rst),
        .we    (table_we),
        .waddr (cfg_layer),
        .wdata (cfg_wdata),
        .raddr (layer_index),
        .rdata (cur_cfg)
    );

    assign last_job = (layer_index == last_layer) && (p_index == cur_cfg.num_p);

`ifdef LAYER_SEQ_TIMEOUT_EN
    logic [31:0] wait_cnt;
    logic        timeout_flag;

    assign wait_expired = (wait_cnt == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge m_clk) begin
        if (!rst) begin
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
            if ((state == IDLE) && start) begin
                timeout_flag <= 1'b0;
            end else if ((state == WAIT) && !all_done && wait_expired) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign timeout = timeout_flag;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign wait_expired       = 1'b0;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge m_clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // all_done is deliberately ignored in ISSUE so a level left over from the previous job cannot retire this one.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT: begin
                if (all_done)          state_next = NEXT;
                else if (wait_expired) state_next = DONE;
            end
            NEXT:    state_next = last_job ? DONE : ISSUE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge m_clk) begin
        if (!rst) begin
            layer_index <= '0;
            p_index     <= '0;
            last_layer  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        last_layer  <= num_layers;
                        layer_index <= '0;
                        p_index     <= '0;
                    end
                end
                NEXT: begin
                    if (!last_job) begin
                        if (p_index == cur_cfg.num_p) begin
                            p_index     <= '0;
                            layer_index <= layer_index + IDX_W'(1);
                        end else begin
                            p_index <= p_index + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    layer_index <= '0;
                    p_index     <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dis_en   = (state == ISSUE) || (state == WAIT);
        need_act = dis_en && cur_cfg.need_act;
        busy     = (state != IDLE);
        done     = (state == DONE);
    end
endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: a reference model of the layer table predicts the job
// sequence, a responder plays the distributor. Define LAYER_SEQ_TIMEOUT_EN to add the watchdog run.
`timescale 1ns/1ps
module tb_layer_sequencer;
`ifdef LAYER_SEQ_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 1024;
`endif
    localparam logic [9:0] DONE_EV = 10'h200;
    localparam int R_DELAY = 0;
    localparam int R_STALE = 1;
    localparam int R_NEVER = 2;

    logic       m_clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       cfg_we = 1'b0;
    logic       cfg_need_act = 1'b0;
    logic       all_done = 1'b0;
    logic [3:0] num_layers = '0;
    logic [3:0] cfg_layer = '0;
    logic [3:0] cfg_num_p = '0;
    logic       dis_en;
    logic       need_act;
    logic       busy;
    logic       done;
    logic       timeout;
    logic [3:0] layer_index;
    logic [3:0] p_index;

    int         tests = 0;
    int         fails = 0;
    logic [9:0] exp_q[$];
    int         m_nump[16];
    bit         m_act[16];
    int         resp_mode = R_DELAY;
    int         resp_delay = 3;

    always #5 m_clk = ~m_clk;

    layer_sequencer #(.TIMEOUT_CYC(TO_CYC)) dut (
        .m_clk        (m_clk),
        .rst          (rst),
        .start        (start),
        .num_layers   (num_layers),
        .cfg_we       (cfg_we),
        .cfg_layer    (cfg_layer),
        .cfg_num_p    (cfg_num_p),
        .cfg_need_act (cfg_need_act),
        .all_done     (all_done),
        .dis_en       (dis_en),
        .layer_index  (layer_index),
        .p_index      (p_index),
        .need_act     (need_act),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        tests++;
        fails++;
        $display("FAIL %s: %s", name, why);
    endtask

    // Distributor stand-in: raises all_done resp_delay WAIT cycles after each job starts.
    initial begin : responder
        int   rcnt;
        logic rprev;
        rcnt  = 0;
        rprev = 1'b0;
        forever begin
            @(negedge m_clk);
            if (resp_mode == R_STALE) begin
                all_done = 1'b1;
            end else if (resp_mode == R_NEVER) begin
                all_done = 1'b0;
            end else if (dis_en && !rprev) begin
                rcnt     = resp_delay;
                all_done = 1'b0;
            end else if (dis_en) begin
                if (rcnt > 0) rcnt--;
                all_done = (rcnt == 0);
            end else begin
                all_done = 1'b0;
            end
            rprev = dis_en;
        end
    end

    initial begin : monitor
        logic       prev_en;
        logic [9:0] cur;
        logic [9:0] e;
        prev_en = 1'b0;
        cur     = '0;
        forever begin
            @(negedge m_clk);
            if (rst) begin
                if (dis_en && !prev_en) begin
                    cur = {1'b0, layer_index, p_index, need_act};
                    if (exp_q.size() == 0) begin
                        fail_now("job", $sformatf("unexpected job 0x%0h, required none", cur));
                    end else begin
                        e = exp_q.pop_front();
                        check("job", 32'(cur), 32'(e));
                    end
                end else if (dis_en) begin
                    check("job_stable", 32'({1'b0, layer_index, p_index, need_act}), 32'(cur));
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        fail_now("done_pulse", "unexpected done pulse, required none");
                    end else begin
                        e = exp_q.pop_front();
                        check("done_order", 32'(e), 32'(DONE_EV));
                    end
                end
            end
            prev_en = rst ? dis_en : 1'b0;
        end
    end

    task automatic do_reset(input int cyc);
        @(posedge m_clk);
        #1;
        rst    = 1'b0;
        start  = 1'b0;
        cfg_we = 1'b0;
        repeat (cyc) @(posedge m_clk);
        #1;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            m_nump[i] = 0;
            m_act[i]  = 1'b0;
        end
        check("reset_outputs",
              32'({dis_en, busy, done, timeout, need_act, layer_index, p_index}), 32'd0);
        rst = 1'b1;
    endtask

    task automatic cfg_write(input int l, input int np, input bit a);
        @(posedge m_clk);
        #1;
        cfg_we       = 1'b1;
        cfg_layer    = 4'(l);
        cfg_num_p    = 4'(np);
        cfg_need_act = a;
        @(posedge m_clk);
        #1;
        cfg_we    = 1'b0;
        m_nump[l] = np;
        m_act[l]  = a;
    endtask

    task automatic push_jobs(input int nl);
        for (int l = 0; l <= nl; l++) begin
            for (int p = 0; p <= m_nump[l]; p++) begin
                exp_q.push_back({1'b0, 4'(l), 4'(p), m_act[l]});
            end
        end
        exp_q.push_back(DONE_EV);
    endtask

    // One complete run; wl >= 0 also writes a table entry in the start cycle.
    task automatic run(input string name, input int nl, input int wl, input int wn,
                       input bit wa, input bit expect_to);
        int jobs;
        int n;
        int want;
        bit seen;
        @(posedge m_clk);
        #1;
        if (wl >= 0) begin
            cfg_we       = 1'b1;
            cfg_layer    = 4'(wl);
            cfg_num_p    = 4'(wn);
            cfg_need_act = wa;
            m_nump[wl]   = wn;
            m_act[wl]    = wa;
        end
        if (expect_to) begin
            exp_q.push_back({1'b0, 4'd0, 4'd0, m_act[0]});
            exp_q.push_back(DONE_EV);
            want = TO_CYC + 2;
        end else begin
            jobs = 0;
            for (int l = 0; l <= nl; l++) jobs += m_nump[l] + 1;
            push_jobs(nl);
            want = jobs * ((resp_mode == R_STALE) ? 3 : resp_delay + 2) + 1;
        end
        num_layers = 4'(nl);
        start      = 1'b1;
        @(posedge m_clk);
        #1;
        start  = 1'b0;
        cfg_we = 1'b0;
        n      = 0;
        seen   = 1'b0;
        while (!seen && n < 3000) begin
            @(negedge m_clk);
            n++;
            if (n == 1) begin
                check({name, "_busy_on"}, 32'(busy), 32'd1);
                check({name, "_timeout_clr"}, 32'(timeout), 32'd0);
            end
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            fail_now({name, "_done"}, "no done pulse within 3000 cycles");
        end else begin
            check({name, "_cycles"}, 32'(n), 32'(want));
            if (expect_to) check({name, "_timeout_set"}, 32'({dis_en, timeout}), 32'd1);
            @(negedge m_clk);
            check({name, "_busy_off"}, 32'(busy), 32'd0);
            check({name, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin : global_limit
        #2ms;
        $display("FAIL global_timeout: simulation exceeded 2 ms, required completion");
        $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        int wl;
        do_reset(2);

        cfg_write(0, 2, 1'b0);
        cfg_write(1, 1, 1'b1);
        resp_mode  = R_DELAY;
        resp_delay = 3;
        run("basic", 1, -1, 0, 1'b0, 1'b0);

        resp_mode = R_STALE;
        run("stale", 1, -1, 0, 1'b0, 1'b0);

        resp_mode  = R_DELAY;
        resp_delay = 2;
        run("wr_start", 0, 0, 3, 1'b1, 1'b0);

        cfg_write(0, 0, 1'b1);
        resp_delay = 8;
        fork
            run("single", 0, -1, 0, 1'b0, 1'b0);
            begin
                repeat (3) @(posedge m_clk);
                #1;
                start        = 1'b1;
                num_layers   = 4'd5;
                cfg_we       = 1'b1;
                cfg_layer    = 4'd0;
                cfg_num_p    = 4'd7;
                cfg_need_act = 1'b0;
                @(posedge m_clk);
                #1;
                start  = 1'b0;
                cfg_we = 1'b0;
            end
        join
        resp_delay = 1;
        run("single_again", 0, -1, 0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int l = 0; l < 4; l++) cfg_write(l, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            resp_delay = int'($urandom_range(1, 4));
            wl = (r % 2 == 1) ? int'($urandom_range(0, 3)) : -1;
            run($sformatf("rand%0d", r), int'($urandom_range(0, 3)), wl,
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        end

        for (int l = 0; l < 16; l++) cfg_write(l, 15, 1'($urandom_range(0, 1)));
        resp_mode = R_STALE;
        run("max", 15, -1, 0, 1'b0, 1'b0);

        cfg_write(0, 3, 1'b1);
        cfg_write(1, 3, 1'b0);
        resp_mode  = R_DELAY;
        resp_delay = 5;
        @(posedge m_clk);
        #1;
        push_jobs(1);
        num_layers = 4'd1;
        start      = 1'b1;
        @(posedge m_clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge m_clk);
        do_reset(2);
        resp_mode = R_STALE;
        run("post_reset_table", 15, -1, 0, 1'b0, 1'b0);

`ifdef LAYER_SEQ_TIMEOUT_EN
        cfg_write(0, 2, 1'b1);
        resp_mode = R_NEVER;
        run("wdog", 2, -1, 0, 1'b0, 1'b1);
        resp_mode  = R_DELAY;
        resp_delay = 2;
        run("after_wdog", 0, -1, 0, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
